// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    ERR     = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in ID/EX feeds a source
// register read by the instruction in IF/ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             memR_i,
  input  logic [REG_W-1:0] gprDes_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             useRt_i,
  output logic             luse_o
);

  logic hit_rs, hit_rt;

  assign hit_rs = (gprDes_i == rs_i);
  assign hit_rt = useRt_i & (gprDes_i == rt_i);
  assign luse_o = memR_i & (gprDes_i != ZERO_REG)
                & (hit_rs | hit_rt);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline.
// Optional perf counters: define PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_memR,
  input  logic [REG_W-1:0] idex_gprDes,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_useRt,
  input  logic             exmem_pcSel,
  input  logic             exmem_memAcc,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
);

  state_e state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic mem_err_q;
  logic luse, mwait, last_wait;

  hazard_detect u_hd (
    .memR_i   (idex_memR),
    .gprDes_i (idex_gprDes),
    .rs_i     (ifid_rs),
    .rt_i     (ifid_rt),
    .useRt_i  (ifid_useRt),
    .luse_o   (luse)
  );

  assign mwait     = exmem_memAcc & ~dmem_ready;
  assign last_wait = (cnt_q == TO_W'(MEM_TIMEOUT - 1));
  assign mem_err   = mem_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= (state_d == ERR);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    unique case (state_q)
      INIT: begin
        {pc_write, ifid_write, idex_write} = 3'b000;
        {exmem_write, memwb_write} = 2'b00;
        {ifid_flush, idex_flush} = 2'b11;
        {exmem_flush, memwb_flush} = 2'b11;
        state_d = RUN;
      end
      RUN: begin
        if (mwait) begin
          {pc_write, ifid_write} = 2'b00;
          {idex_write, exmem_write} = 2'b00;
          memwb_flush = 1'b1;
          cnt_d       = TO_W'(1);
          state_d     = MEMWAIT;
        end else if (exmem_pcSel) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (luse) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
      MEMWAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          if (exmem_pcSel) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end
        end else begin
          {pc_write, ifid_write} = 2'b00;
          {idex_write, exmem_write} = 2'b00;
          memwb_flush = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (last_wait) state_d = ERR;
        end
      end
      ERR: begin
        {pc_write, ifid_write, idex_write} = 3'b000;
        {exmem_write, memwb_write} = 2'b00;
        memwb_flush = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, flush_q;
  logic        active;

  // INIT and ERR cycles are not pipeline activity.
  assign active = (state_q == RUN) | (state_q == MEMWAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(active & ~pc_write);
      flush_q <= flush_q + 32'(active & ifid_flush);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
